// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit signed ALU between the execute stage (port 0)
// and the branch/compare unit (port 1); screens illegal opcodes and divide/modulo by zero.
module alu_arbiter #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned NOP_OP      = 17,
  parameter int unsigned MAX_OP      = 18
) (
  input  logic        Fast_Clock,
  input  logic        Reset_N,
  input  logic        Req_0,
  input  logic [4:0]  Op_0,
  input  logic [31:0] A_0,
  input  logic [31:0] B_0,
  input  logic        Req_1,
  input  logic [4:0]  Op_1,
  input  logic [31:0] A_1,
  input  logic [31:0] B_1,
  output logic        Grant_0,
  output logic        Grant_1,
  output logic        Done_0,
  output logic        Done_1,
  output logic [31:0] Resp_Result,
  output logic        Resp_True,
  output logic        Resp_Error,
  output logic        Busy,
  output logic [4:0]  ALU_Op,
  output logic [31:0] ALU_In_1,
  output logic [31:0] ALU_In_2,
  input  logic [31:0] ALU_Result,
  input  logic        ALU_True
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] NOP_CODE = OP_W'(NOP_OP);
  localparam logic [OP_W-1:0] MAX_CODE = OP_W'(MAX_OP);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOD   = OP_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;

  logic                grant_0_d, grant_1_d, done_0_d, done_1_d;
  logic [DATA_W-1:0]   resp_result_d;
  logic                resp_true_d, resp_error_d, busy_d;
  logic [OP_W-1:0]     alu_op_d;
  logic [DATA_W-1:0]   alu_in_1_d, alu_in_2_d;

  logic                winner;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic                reject;

  // Winner selection: a tie goes to the requester that was not granted last
  always_comb begin
    winner = (Req_0 && Req_1) ? ~last_grant_q : Req_1;
    sel_op = winner ? Op_1 : Op_0;
    sel_a  = winner ? A_1  : A_0;
    sel_b  = winner ? B_1  : B_0;
    reject = (sel_op > MAX_CODE) ||
             (((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0));
  end

  always_ff @(posedge Fast_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      Grant_0      <= 1'b0;
      Grant_1      <= 1'b0;
      Done_0       <= 1'b0;
      Done_1       <= 1'b0;
      Resp_Result  <= '0;
      Resp_True    <= 1'b0;
      Resp_Error   <= 1'b0;
      Busy         <= 1'b0;
      ALU_Op       <= NOP_CODE;
      ALU_In_1     <= '0;
      ALU_In_2     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      Grant_0      <= grant_0_d;
      Grant_1      <= grant_1_d;
      Done_0       <= done_0_d;
      Done_1       <= done_1_d;
      Resp_Result  <= resp_result_d;
      Resp_True    <= resp_true_d;
      Resp_Error   <= resp_error_d;
      Busy         <= busy_d;
      ALU_Op       <= alu_op_d;
      ALU_In_1     <= alu_in_1_d;
      ALU_In_2     <= alu_in_2_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    grant_0_d     = 1'b0;
    grant_1_d     = 1'b0;
    done_0_d      = 1'b0;
    done_1_d      = 1'b0;
    resp_result_d = Resp_Result;
    resp_true_d   = Resp_True;
    resp_error_d  = Resp_Error;
    alu_op_d      = ALU_Op;
    alu_in_1_d    = ALU_In_1;
    alu_in_2_d    = ALU_In_2;

    case (state_q)
      IDLE: begin
        if (Req_0 || Req_1) begin
          last_grant_d = winner;
          owner_d      = winner;
          grant_0_d    = ~winner;
          grant_1_d    = winner;
          if (reject) begin
            // Rejected requests complete immediately without touching the ALU
            resp_result_d = '0;
            resp_true_d   = 1'b0;
            resp_error_d  = 1'b1;
            done_0_d      = ~winner;
            done_1_d      = winner;
            alu_op_d      = NOP_CODE;
            state_d       = RESP;
          end else begin
            alu_op_d   = sel_op;
            alu_in_1_d = sel_a;
            alu_in_2_d = sel_b;
            count_d    = CNT_W'(ALU_LATENCY);
            state_d    = EXEC;
          end
        end
      end
      EXEC: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          resp_result_d = ALU_Result;
          resp_true_d   = ALU_True;
          resp_error_d  = 1'b0;
          done_0_d      = ~owner_q;
          done_1_d      = owner_q;
          state_d       = RESP;
        end
      end
      RESP: begin
        alu_op_d = NOP_CODE;
        state_d  = IDLE;
      end
      default: begin
        alu_op_d = NOP_CODE;
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
